// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its painter / DAC pins.
// The generator (master) paces pixels with ptick; the painter (slave) answers with pixel_rgb.
interface vga_timing_gen_if;
  logic [2:0] pixel_rgb;
  logic       hsync;
  logic       vsync;
  logic       red;
  logic       green;
  logic       blue;
  logic       active;
  logic       ptick;
  logic       ftick;
  logic [9:0] xpos;
  logic [9:0] ypos;

  // Pacing contract: when ptick is high, the painter must present pixel_rgb for the
  // current (xpos, ypos) by the next clk_50 edge; there is no back-pressure.
  modport master (
    input  pixel_rgb,
    output hsync, vsync, red, green, blue, active, ptick, ftick, xpos, ypos
  );

  modport slave (
    output pixel_rgb,
    input  hsync, vsync, red, green, blue, active, ptick, ftick, xpos, ypos
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from a 50 MHz clock: pixel pacing, coordinates, syncs,
// frame tick, and registered, blanked RGB out to the DAC.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk_50,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       ptick_q,  ptick_d;
  logic [9:0] xpos_q,   xpos_d;
  logic [9:0] ypos_q,   ypos_d;
  logic       hsync_q,  hsync_d;
  logic       vsync_q,  vsync_d;
  logic       active_q, active_d;
  logic       ftick_q,  ftick_d;
  logic [2:0] rgb_q,    rgb_d;

  always_comb begin
    ptick_d  = ~ptick_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    ftick_d  = 1'b0;
    rgb_d    = rgb_q;

    if (ptick_q) begin
      if (xpos_q == H_LAST) begin
        xpos_d = 10'd0;
        ypos_d = (ypos_q == V_LAST) ? 10'd0 : ypos_q + 10'd1;
      end else begin
        xpos_d = xpos_q + 10'd1;
      end

      // Flags decode the coordinates being moved to, so they match xpos/ypos as presented.
      active_d = (xpos_d < H_VIS) && (ypos_d < V_VIS);
      hsync_d  = ((xpos_d >= HS_START) && (xpos_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = ((ypos_d >= VS_START) && (ypos_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      ftick_d  = (xpos_d == 10'd0) && (ypos_d == V_VIS);

      // Painter colour belongs to the position presented before this edge.
      rgb_d    = active_q ? vga.pixel_rgb : 3'b000;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      ptick_q  <= 1'b0;
      xpos_q   <= 10'd0;
      ypos_q   <= 10'd0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b0;
      ftick_q  <= 1'b0;
      rgb_q    <= 3'b000;
    end else begin
      ptick_q  <= ptick_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      ftick_q  <= ftick_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vga.ptick  = ptick_q;
  assign vga.xpos   = xpos_q;
  assign vga.ypos   = ypos_q;
  assign vga.hsync  = hsync_q;
  assign vga.vsync  = vsync_q;
  assign vga.active = active_q;
  assign vga.ftick  = ftick_q;
  assign vga.red    = rgb_q[2];
  assign vga.green  = rgb_q[1];
  assign vga.blue   = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line/RGB behaviour, a shrunken
// instance for frame timing and mid-frame reset, both against a position-count model.
module tb_vga_timing_gen;

  logic clk_50 = 1'b0;
  logic reset_a;
  logic reset_b;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen dut_a (
    .clk_50 (clk_50),
    .reset  (reset_a),
    .vga    (vif_a.master)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_b (
    .clk_50 (clk_50),
    .reset  (reset_b),
    .vga    (vif_b.master)
  );

  // clock / watchdog
  always #10 clk_50 = ~clk_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // {ptick, hsync, vsync, active, ftick, r, g, b, xpos, ypos}
  localparam logic [27:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 10'd0, 10'd0};

  logic [27:0] act_a, act_b, exp_v;
  assign act_a = {vif_a.ptick, vif_a.hsync, vif_a.vsync, vif_a.active, vif_a.ftick,
                  vif_a.red, vif_a.green, vif_a.blue, vif_a.xpos, vif_a.ypos};
  assign act_b = {vif_b.ptick, vif_b.hsync, vif_b.vsync, vif_b.active, vif_b.ftick,
                  vif_b.red, vif_b.green, vif_b.blue, vif_b.xpos, vif_b.ypos};

  int n_checks = 0;
  int n_pass   = 0;
  int na, nb;
  logic [2:0] drv_a, smp_a, drv_b, smp_b;

  // Reference model: n = clk_50 edges since reset release, pixel p = n/2 positions
  // advanced in raster order; smp = colour applied at the most recent pixel edge.
  function automatic logic [27:0] model(int n, logic [2:0] smp,
                                        int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p  = n / 2;
    int x  = p % ht;
    int y  = (p / ht) % vt;
    int px = (p > 0) ? (p - 1) % ht : 0;
    int py = (p > 0) ? ((p - 1) / ht) % vt : 0;
    logic act, pact, hs_o, vs_o, ft, pt;
    logic [2:0] rgb;
    pt   = (n % 2) == 1;
    act  = (p >= 1) && (x < ha) && (y < va);
    pact = (p >= 2) && (px < ha) && (py < va);
    hs_o = !((x >= ha + hf) && (x < ha + hf + hs));
    vs_o = !((y >= va + vf) && (y < va + vf + vs));
    ft   = ((n % 2) == 0) && (p >= 1) && (x == 0) && (y == va);
    rgb  = pact ? smp : 3'b000;
    return {pt, hs_o, vs_o, act, ft, rgb, 10'(x), 10'(y)};
  endfunction

  function automatic logic [27:0] model_a(int n, logic [2:0] smp);
    return model(n, smp, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [27:0] model_b(int n, logic [2:0] smp);
    return model(n, smp, 8, 2, 2, 2, 4, 1, 1, 1);
  endfunction

  // driver tasks
  task automatic drive_a(input logic [2:0] v);
    drv_a = v;
    vif_a.pixel_rgb = v;
  endtask

  task automatic drive_b(input logic [2:0] v);
    drv_b = v;
    vif_b.pixel_rgb = v;
  endtask

  task automatic step_a();
    @(posedge clk_50); #1;
    na++;
    if (na % 2 == 0) smp_a = drv_a;
  endtask

  task automatic step_b();
    @(posedge clk_50); #1;
    nb++;
    if (nb % 2 == 0) smp_b = drv_b;
  endtask

  task automatic test_reset();
    reset_a = 1'b1;
    drive_a(3'b000);
    repeat (3) @(posedge clk_50);
    #1;
    n_checks++;
    if (act_a !== RST_VEC) $display("FAIL reset_state got=%h exp=%h", act_a, RST_VEC);
    else n_pass++;

    drive_a(3'b110);
    @(posedge clk_50); #1;
    n_checks++;
    if (act_a !== RST_VEC) $display("FAIL reset_ignores_rgb got=%h exp=%h", act_a, RST_VEC);
    else n_pass++;

    reset_a = 1'b0;
    na = 0;
    smp_a = 3'b000;
    for (int i = 0; i < 620; i++) begin
      step_a();
      exp_v = model_a(na, smp_a);
      n_checks++;
      if (act_a !== exp_v) $display("FAIL release_model n=%0d got=%h exp=%h", na, act_a, exp_v);
      else n_pass++;
      drive_a(3'($urandom_range(0, 7)));
    end

    // asynchronous assertion well away from any clock edge
    #3 reset_a = 1'b1;
    #1;
    n_checks++;
    if (act_a !== RST_VEC) $display("FAIL async_reset_a got=%h exp=%h", act_a, RST_VEC);
    else n_pass++;
    repeat (3) @(posedge clk_50);
    #1;
    n_checks++;
    if (act_a !== RST_VEC) $display("FAIL reset_hold_a got=%h exp=%h", act_a, RST_VEC);
    else n_pass++;

    reset_a = 1'b0;
    na = 0;
    smp_a = 3'b000;
    for (int i = 0; i < 40; i++) begin
      step_a();
      exp_v = model_a(na, smp_a);
      n_checks++;
      if (act_a !== exp_v) $display("FAIL restart_model n=%0d got=%h exp=%h", na, act_a, exp_v);
      else n_pass++;
      drive_a(3'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_line();
    int w1 = -1;
    int w2 = -1;
    int low = 0;
    logic [9:0] prev_x = vif_a.xpos;
    for (int i = 0; i < 3300; i++) begin
      step_a();
      exp_v = model_a(na, smp_a);
      n_checks++;
      if (act_a !== exp_v) $display("FAIL line_model n=%0d got=%h exp=%h", na, act_a, exp_v);
      else n_pass++;
      if (vif_a.xpos == 10'd0 && prev_x != 10'd0) begin
        if (w1 < 0) w1 = na;
        else if (w2 < 0) w2 = na;
      end
      if (w1 >= 0 && w2 < 0 && vif_a.hsync == 1'b0) low++;
      prev_x = vif_a.xpos;
      drive_a(3'($urandom_range(0, 7)));
    end
    n_checks++;
    if (w2 - w1 !== 1600) $display("FAIL line_period got=%0d exp=1600", w2 - w1);
    else n_pass++;
    n_checks++;
    if (low !== 192) $display("FAIL hsync_width got=%0d exp=192", low);
    else n_pass++;
  endtask

  task automatic test_rgb();
    int w1 = -1;
    int w2 = -1;
    int on_cnt = 0;
    logic [9:0] prev_x = vif_a.xpos;
    drive_a(3'b101);
    for (int i = 0; i < 3300; i++) begin
      step_a();
      exp_v = model_a(na, smp_a);
      n_checks++;
      if (act_a !== exp_v) $display("FAIL rgb_model n=%0d got=%h exp=%h", na, act_a, exp_v);
      else n_pass++;
      if (vif_a.xpos == 10'd0 && prev_x != 10'd0) begin
        if (w1 < 0) w1 = na;
        else if (w2 < 0) w2 = na;
      end
      if (w1 >= 0 && w2 < 0 && {vif_a.red, vif_a.green, vif_a.blue} == 3'b101) on_cnt++;
      prev_x = vif_a.xpos;
    end
    n_checks++;
    if (on_cnt !== 1280) $display("FAIL rgb_on_count got=%0d exp=1280", on_cnt);
    else n_pass++;
  endtask

  task automatic test_frame();
    int f_q[$];
    int vlow = 0;
    int sp1, sp2;
    drive_b(3'($urandom_range(0, 7)));
    reset_b = 1'b0;
    nb = 0;
    smp_b = 3'b000;
    for (int i = 0; i < 640; i++) begin
      step_b();
      exp_v = model_b(nb, smp_b);
      n_checks++;
      if (act_b !== exp_v) $display("FAIL frame_model n=%0d got=%h exp=%h", nb, act_b, exp_v);
      else n_pass++;
      if (vif_b.ftick) f_q.push_back(nb);
      if (f_q.size() == 1 && vif_b.vsync == 1'b0) vlow++;
      drive_b(3'($urandom_range(0, 7)));
    end
    sp1 = (f_q.size() >= 2) ? f_q[1] - f_q[0] : -1;
    sp2 = (f_q.size() >= 3) ? f_q[2] - f_q[1] : -1;
    n_checks++;
    if (f_q.size() !== 3) $display("FAIL ftick_count got=%0d exp=3", f_q.size());
    else n_pass++;
    n_checks++;
    if (((f_q.size() >= 1) ? f_q[0] : -1) !== 112)
      $display("FAIL ftick_first got=%0d exp=112", (f_q.size() >= 1) ? f_q[0] : -1);
    else n_pass++;
    n_checks++;
    if (sp1 !== 196 || sp2 !== 196) $display("FAIL ftick_spacing got=%0d,%0d exp=196,196", sp1, sp2);
    else n_pass++;
    n_checks++;
    if (vlow !== 28) $display("FAIL vsync_width got=%0d exp=28", vlow);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic found = 1'b0;
    int first_ft = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      step_b();
      exp_v = model_b(nb, smp_b);
      n_checks++;
      if (act_b !== exp_v) $display("FAIL pre_reset_model n=%0d got=%h exp=%h", nb, act_b, exp_v);
      else n_pass++;
      if (vif_b.xpos == 10'd3 && vif_b.ypos == 10'd2) found = 1'b1;
      drive_b(3'($urandom_range(0, 7)));
    end
    n_checks++;
    if (found !== 1'b1) $display("FAIL reach_3_2 got=%0b exp=1", found);
    else n_pass++;

    #3 reset_b = 1'b1;
    #1;
    n_checks++;
    if (act_b !== RST_VEC) $display("FAIL async_reset_b got=%h exp=%h", act_b, RST_VEC);
    else n_pass++;
    repeat (3) @(posedge clk_50);
    #1;
    n_checks++;
    if (act_b !== RST_VEC) $display("FAIL reset_hold_b got=%h exp=%h", act_b, RST_VEC);
    else n_pass++;

    reset_b = 1'b0;
    nb = 0;
    smp_b = 3'b000;
    for (int i = 0; i < 250; i++) begin
      step_b();
      exp_v = model_b(nb, smp_b);
      n_checks++;
      if (act_b !== exp_v) $display("FAIL post_reset_model n=%0d got=%h exp=%h", nb, act_b, exp_v);
      else n_pass++;
      if (vif_b.ftick && first_ft < 0) first_ft = nb;
      drive_b(3'($urandom_range(0, 7)));
    end
    n_checks++;
    if (first_ft !== 112) $display("FAIL first_ftick_after_reset got=%0d exp=112", first_ft);
    else n_pass++;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive_a(3'b000);
    drive_b(3'b000);
    smp_a = 3'b000;
    smp_b = 3'b000;
    test_reset();
    test_line();
    test_rgb();
    test_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
